// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle core: opcodes, ALU selects, instruction field positions, status codes.
package mips_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_J     = 5'b00001;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;

   localparam logic [4:0] ALUOP_ADD = 5'b00000;
   localparam logic [4:0] ALUOP_SUB = 5'b00001;
   localparam logic [4:0] ALUOP_AND = 5'b00010;
   localparam logic [4:0] ALUOP_OR  = 5'b00011;
   localparam logic [4:0] ALUOP_SLL = 5'b00100;
   localparam logic [4:0] ALUOP_SRA = 5'b00101;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 27;
   localparam int RD_HI     = 26;
   localparam int RD_LO     = 22;
   localparam int RS_HI     = 21;
   localparam int RS_LO     = 17;
   localparam int RT_HI     = 16;
   localparam int RT_LO     = 12;
   localparam int SHAMT_HI  = 11;
   localparam int SHAMT_LO  = 7;
   localparam int ALUOP_HI  = 6;
   localparam int ALUOP_LO  = 2;
   localparam int IMM_HI    = 16;
   localparam int IMM_LO    = 0;
   localparam int PC_W      = 12;

   localparam logic [31:0] STATUS_ADD  = 32'd1;
   localparam logic [31:0] STATUS_ADDI = 32'd2;
   localparam logic [31:0] STATUS_SUB  = 32'd3;
   localparam logic [4:0]  STATUS_REG  = 5'd30;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLL,
      ALU_SRA
   } alu_op_e;

   function automatic logic [31:0] sign_ext_imm(input logic [16:0] imm);
      return {{15{imm[16]}}, imm};
   endfunction

endpackage

// File: rtl/mips_alu.sv
// 32-bit ALU: add/sub/and/or/sll/sra with signed-overflow flag and an inequality compare.
// Purely combinational, zero latency, no flow control.
module mips_alu
   import mips_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   input  alu_op_e     op,
   output logic [31:0] result,
   output logic        overflow,
   output logic        not_equal
);

   logic [31:0] sum;
   logic [31:0] diff;

   assign sum       = a + b;
   assign diff      = a - b;
   assign not_equal = (a != b);

   always_comb begin
      result   = sum;
      overflow = 1'b0;
      case (op)
         ALU_ADD: begin
            result   = sum;
            overflow = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         ALU_SUB: begin
            result   = diff;
            overflow = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLL: result = a << shamt;
         ALU_SRA: result = $signed(a) >>> shamt;
         default: result = sum;
      endcase
   end

endmodule

// File: rtl/mips_processor.sv
// Single-cycle core: one instruction per clock, outputs combinational from PC/imem/regfile/dmem, no stalls.
// Optional OVF_STATUS_EN: overflowing add/addi/sub write a status code to r30 instead of rd.
module mips_processor
   import mips_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   output logic [11:0] address_imem,
   input  logic [31:0] q_imem,
   output logic [11:0] address_dmem,
   output logic [31:0] data,
   output logic        wren,
   input  logic [31:0] q_dmem,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [4:0]  ctrl_readRegA,
   output logic [4:0]  ctrl_readRegB,
   output logic [31:0] data_writeReg,
   input  logic [31:0] data_readRegA,
   input  logic [31:0] data_readRegB
);

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_plus1;
   logic [PC_W-1:0] pc_next;

   logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
   logic [31:0] imm_ext;
   logic        is_rtype, is_j, is_bne, is_addi, is_sw, is_lw;

   alu_op_e     alu_op;
   logic        rtype_valid;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        alu_overflow;
   logic        alu_not_equal;

   logic        wr_en;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;

   assign opcode  = q_imem[OPCODE_HI:OPCODE_LO];
   assign rd      = q_imem[RD_HI:RD_LO];
   assign rs      = q_imem[RS_HI:RS_LO];
   assign rt      = q_imem[RT_HI:RT_LO];
   assign shamt   = q_imem[SHAMT_HI:SHAMT_LO];
   assign aluop   = q_imem[ALUOP_HI:ALUOP_LO];
   assign imm_ext = sign_ext_imm(q_imem[IMM_HI:IMM_LO]);

   assign is_rtype = (opcode == OP_RTYPE);
   assign is_j     = (opcode == OP_J);
   assign is_bne   = (opcode == OP_BNE);
   assign is_addi  = (opcode == OP_ADDI);
   assign is_sw    = (opcode == OP_SW);
   assign is_lw    = (opcode == OP_LW);

   // sw reads its store data through port B; bne compares $rd (A) against $rs (B)
   assign ctrl_readRegA = is_bne ? rd : rs;
   assign ctrl_readRegB = is_sw ? rd : (is_bne ? rs : rt);

   always_comb begin
      alu_op      = ALU_ADD;
      rtype_valid = 1'b0;
      if (is_rtype) begin
         rtype_valid = 1'b1;
         case (aluop)
            ALUOP_ADD: alu_op = ALU_ADD;
            ALUOP_SUB: alu_op = ALU_SUB;
            ALUOP_AND: alu_op = ALU_AND;
            ALUOP_OR:  alu_op = ALU_OR;
            ALUOP_SLL: alu_op = ALU_SLL;
            ALUOP_SRA: alu_op = ALU_SRA;
            default:   rtype_valid = 1'b0;
         endcase
      end
   end

   assign alu_b = (is_addi || is_sw || is_lw) ? imm_ext : data_readRegB;

   mips_alu u_alu (
      .a         (data_readRegA),
      .b         (alu_b),
      .shamt     (shamt),
      .op        (alu_op),
      .result    (alu_result),
      .overflow  (alu_overflow),
      .not_equal (alu_not_equal)
   );

   always_comb begin
      wr_en   = 1'b0;
      wr_reg  = rd;
      wr_data = alu_result;
      if (is_rtype) begin
         wr_en = rtype_valid;
      end else if (is_addi) begin
         wr_en = 1'b1;
      end else if (is_lw) begin
         wr_en   = 1'b1;
         wr_data = q_dmem;
      end
      if (rd == 5'd0) begin
         wr_en = 1'b0;
      end
`ifdef OVF_STATUS_EN
      // status lands in r30 regardless of rd, so an overflow into r0 is still reported
      if (alu_overflow && ((is_rtype && rtype_valid) || is_addi)) begin
         wr_en   = 1'b1;
         wr_reg  = STATUS_REG;
         wr_data = is_addi ? STATUS_ADDI :
                   (alu_op == ALU_SUB) ? STATUS_SUB : STATUS_ADD;
      end
`endif
   end

`ifndef OVF_STATUS_EN
   logic unused_alu_overflow;
   assign unused_alu_overflow = alu_overflow;
`endif

   assign ctrl_writeEnable = wr_en && !reset;
   assign ctrl_writeReg    = wr_reg;
   assign data_writeReg    = wr_data;

   assign address_dmem = alu_result[11:0];
   assign data         = data_readRegB;
   assign wren         = is_sw && !reset;

   assign pc_plus1 = pc + 12'd1;

   always_comb begin
      pc_next = pc_plus1;
      if (is_j) begin
         pc_next = q_imem[11:0];
      end else if (is_bne && alu_not_equal) begin
         pc_next = pc_plus1 + imm_ext[11:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc <= '0;
      end else begin
         pc <= pc_next;
      end
   end

   assign address_imem = pc;

endmodule

// File: tb/tb_mips_processor.sv
// Directed-vector bench for mips_processor; the regfile and memories are modelled by driving their data ports directly.
module tb_mips_processor;

   logic        clock;
   logic        reset;
   logic [11:0] address_imem;
   logic [31:0] q_imem;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic [31:0] data_writeReg;
   logic [31:0] data_readRegA;
   logic [31:0] data_readRegB;

   int checks = 0;
   int fails  = 0;

   mips_processor dut (
      .clock            (clock),
      .reset            (reset),
      .address_imem     (address_imem),
      .q_imem           (q_imem),
      .address_dmem     (address_dmem),
      .data             (data),
      .wren             (wren),
      .q_dmem           (q_dmem),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .ctrl_readRegA    (ctrl_readRegA),
      .ctrl_readRegB    (ctrl_readRegB),
      .data_writeReg    (data_writeReg),
      .data_readRegA    (data_readRegA),
      .data_readRegB    (data_readRegB)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] sh, input logic [4:0] aop);
      return {5'b00000, rd, rs, rt, sh, aop, 2'b00};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [26:0] target);
      return {5'b00001, target};
   endfunction

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // R-type vectors: aluop, rs value, rt value, shamt, expected result, expected write enable
   logic [4:0]  rt_aop [0:6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
   logic [31:0] rt_a   [0:6] = '{32'd5, 32'd5, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000003, 32'h80000000, 32'd1};
   logic [31:0] rt_b   [0:6] = '{32'd7, 32'd7, 32'hFF00FF00, 32'h000000FF, 32'h0, 32'h0, 32'd1};
   logic [4:0]  rt_sh  [0:6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd0};
   logic [31:0] rt_exp [0:6] = '{32'd12, 32'hFFFFFFFE, 32'hF000F000, 32'h0F0F00FF, 32'h00000030, 32'hF8000000, 32'd0};
   logic        rt_we  [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

   task automatic test_reset();
      reset = 1'b1;
      q_imem = enc_i(5'b00111, 5'd1, 5'd2, 17'd4);
      data_readRegA = 32'd8;
      data_readRegB = 32'hDEAD;
      q_dmem = 32'd0;
      tick();
      checks++; if (address_imem !== 12'h000) begin fails++; $display("FAIL reset_pc: got %h want 000", address_imem); end
      checks++; if (wren !== 1'b0) begin fails++; $display("FAIL reset_wren: got %b want 0", wren); end
      q_imem = enc_i(5'b00101, 5'd1, 5'd0, 17'd5);
      #1;
      checks++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", ctrl_writeEnable); end
      tick();
      reset = 1'b0;
      #1;
      checks++; if (address_imem !== 12'h000) begin fails++; $display("FAIL reset_release_pc: got %h want 000", address_imem); end
   endtask

   task automatic test_addi();
      q_imem = enc_i(5'b00101, 5'd1, 5'd0, 17'h0DEAD);
      data_readRegA = 32'd0;
      #1;
      checks++; if (ctrl_readRegA !== 5'd0) begin fails++; $display("FAIL addi_rra: got %0d want 0", ctrl_readRegA); end
      checks++; if (ctrl_writeReg !== 5'd1) begin fails++; $display("FAIL addi_wreg: got %0d want 1", ctrl_writeReg); end
      checks++; if (data_writeReg !== 32'h0000DEAD) begin fails++; $display("FAIL addi_data: got %h want 0000dead", data_writeReg); end
      checks++; if (ctrl_writeEnable !== 1'b1) begin fails++; $display("FAIL addi_we: got %b want 1", ctrl_writeEnable); end
      checks++; if (wren !== 1'b0) begin fails++; $display("FAIL addi_wren: got %b want 0", wren); end
      tick();
      checks++; if (address_imem !== 12'h001) begin fails++; $display("FAIL addi_pc: got %h want 001", address_imem); end
      q_imem = enc_i(5'b00101, 5'd5, 5'd1, 17'h1FFFF);
      data_readRegA = 32'd10;
      #1;
      checks++; if (data_writeReg !== 32'd9) begin fails++; $display("FAIL addi_neg: got %h want 9", data_writeReg); end
      tick();
   endtask

   task automatic test_overflow();
      q_imem = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'd0);
      data_readRegA = 32'h7FFFFFFF;
      data_readRegB = 32'd1;
      #1;
      checks++; if (ctrl_readRegA !== 5'd1 || ctrl_readRegB !== 5'd2) begin fails++; $display("FAIL add_rsel: got %0d/%0d want 1/2", ctrl_readRegA, ctrl_readRegB); end
`ifdef OVF_STATUS_EN
      checks++; if (ctrl_writeReg !== 5'd30 || data_writeReg !== 32'd1) begin fails++; $display("FAIL add_ovf: got r%0d=%h want r30=1", ctrl_writeReg, data_writeReg); end
`else
      checks++; if (ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h80000000) begin fails++; $display("FAIL add_ovf: got r%0d=%h want r3=80000000", ctrl_writeReg, data_writeReg); end
`endif
      checks++; if (ctrl_writeEnable !== 1'b1) begin fails++; $display("FAIL add_ovf_we: got %b want 1", ctrl_writeEnable); end
      tick();
      q_imem = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'd1);
      data_readRegA = 32'h80000000;
      data_readRegB = 32'd1;
      #1;
`ifdef OVF_STATUS_EN
      checks++; if (ctrl_writeReg !== 5'd30 || data_writeReg !== 32'd3) begin fails++; $display("FAIL sub_ovf: got r%0d=%h want r30=3", ctrl_writeReg, data_writeReg); end
`else
      checks++; if (ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h7FFFFFFF) begin fails++; $display("FAIL sub_ovf: got r%0d=%h want r3=7fffffff", ctrl_writeReg, data_writeReg); end
`endif
      tick();
   endtask

   task automatic test_rtype();
      for (int i = 0; i < 7; i++) begin
         q_imem = enc_r(5'd7, 5'd1, 5'd2, rt_sh[i], rt_aop[i]);
         data_readRegA = rt_a[i];
         data_readRegB = rt_b[i];
         #1;
         checks++; if (ctrl_writeEnable !== rt_we[i]) begin fails++; $display("FAIL rtype_we[%0d]: got %b want %b", i, ctrl_writeEnable, rt_we[i]); end
         if (rt_we[i]) begin
            checks++; if (ctrl_writeReg !== 5'd7 || data_writeReg !== rt_exp[i]) begin fails++; $display("FAIL rtype_res[%0d]: got r%0d=%h want r7=%h", i, ctrl_writeReg, data_writeReg, rt_exp[i]); end
         end
         tick();
      end
   endtask

   task automatic test_mem();
      q_imem = enc_i(5'b00111, 5'd1, 5'd2, 17'd4);
      data_readRegA = 32'd8;
      data_readRegB = 32'hDEAD;
      #1;
      checks++; if (ctrl_readRegA !== 5'd2 || ctrl_readRegB !== 5'd1) begin fails++; $display("FAIL sw_rsel: got %0d/%0d want 2/1", ctrl_readRegA, ctrl_readRegB); end
      checks++; if (address_dmem !== 12'd12) begin fails++; $display("FAIL sw_addr: got %0d want 12", address_dmem); end
      checks++; if (data !== 32'hDEAD) begin fails++; $display("FAIL sw_data: got %h want dead", data); end
      checks++; if (wren !== 1'b1) begin fails++; $display("FAIL sw_wren: got %b want 1", wren); end
      checks++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL sw_we: got %b want 0", ctrl_writeEnable); end
      tick();
      q_imem = enc_i(5'b01000, 5'd4, 5'd2, 17'd4);
      q_dmem = 32'h1234;
      #1;
      checks++; if (address_dmem !== 12'd12) begin fails++; $display("FAIL lw_addr: got %0d want 12", address_dmem); end
      checks++; if (ctrl_writeReg !== 5'd4 || data_writeReg !== 32'h1234) begin fails++; $display("FAIL lw_wr: got r%0d=%h want r4=1234", ctrl_writeReg, data_writeReg); end
      checks++; if (wren !== 1'b0 || ctrl_writeEnable !== 1'b1) begin fails++; $display("FAIL lw_en: got wren=%b we=%b want 0/1", wren, ctrl_writeEnable); end
      tick();
   endtask

   task automatic test_branch();
      q_imem = enc_j(27'h005);
      #1;
      checks++; if (ctrl_writeEnable !== 1'b0 || wren !== 1'b0) begin fails++; $display("FAIL j_en: got we=%b wren=%b want 0/0", ctrl_writeEnable, wren); end
      tick();
      checks++; if (address_imem !== 12'h005) begin fails++; $display("FAIL j5_pc: got %h want 005", address_imem); end
      q_imem = enc_i(5'b00010, 5'd1, 5'd2, 17'h1FFFD);
      data_readRegA = 32'd1;
      data_readRegB = 32'd2;
      #1;
      checks++; if (ctrl_readRegA !== 5'd1 || ctrl_readRegB !== 5'd2) begin fails++; $display("FAIL bne_rsel: got %0d/%0d want 1/2", ctrl_readRegA, ctrl_readRegB); end
      tick();
      checks++; if (address_imem !== 12'h003) begin fails++; $display("FAIL bne_taken: got %h want 003", address_imem); end
      data_readRegA = 32'd7;
      data_readRegB = 32'd7;
      tick();
      checks++; if (address_imem !== 12'h004) begin fails++; $display("FAIL bne_not_taken: got %h want 004", address_imem); end
      q_imem = enc_j(27'h00000FF);
      tick();
      checks++; if (address_imem !== 12'h0FF) begin fails++; $display("FAIL j_ff: got %h want 0ff", address_imem); end
   endtask

   task automatic test_boundaries();
      q_imem = enc_i(5'b00101, 5'd0, 5'd0, 17'd5);
      data_readRegA = 32'd0;
      #1;
      checks++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL r0_we: got %b want 0", ctrl_writeEnable); end
      q_imem = enc_j(27'h0000FFF);
      tick();
      checks++; if (address_imem !== 12'hFFF) begin fails++; $display("FAIL j_fff: got %h want fff", address_imem); end
      q_imem = 32'hFFFFFFFF;
      #1;
      checks++; if (ctrl_writeEnable !== 1'b0 || wren !== 1'b0) begin fails++; $display("FAIL unk_en: got we=%b wren=%b want 0/0", ctrl_writeEnable, wren); end
      tick();
      checks++; if (address_imem !== 12'h000) begin fails++; $display("FAIL pc_wrap: got %h want 000", address_imem); end
   endtask

   task automatic test_reset_mid();
      q_imem = enc_j(27'h010);
      tick();
      checks++; if (address_imem !== 12'h010) begin fails++; $display("FAIL mid_j: got %h want 010", address_imem); end
      q_imem = enc_i(5'b00111, 5'd1, 5'd2, 17'd4);
      reset = 1'b1;
      #1;
      checks++; if (wren !== 1'b0) begin fails++; $display("FAIL mid_wren: got %b want 0", wren); end
      q_imem = enc_i(5'b00101, 5'd1, 5'd0, 17'd1);
      #1;
      checks++; if (ctrl_writeEnable !== 1'b0) begin fails++; $display("FAIL mid_we: got %b want 0", ctrl_writeEnable); end
      tick();
      reset = 1'b0;
      #1;
      checks++; if (address_imem !== 12'h000) begin fails++; $display("FAIL mid_pc0: got %h want 000", address_imem); end
      checks++; if (ctrl_writeEnable !== 1'b1) begin fails++; $display("FAIL mid_restart_we: got %b want 1", ctrl_writeEnable); end
      tick();
      checks++; if (address_imem !== 12'h001) begin fails++; $display("FAIL mid_pc1: got %h want 001", address_imem); end
   endtask

   initial begin
      reset = 1'b1;
      q_imem = 32'd0;
      q_dmem = 32'd0;
      data_readRegA = 32'd0;
      data_readRegB = 32'd0;
      test_reset();
      test_addi();
      test_overflow();
      test_rtype();
      test_mem();
      test_branch();
      test_boundaries();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mips_processor.md
# mips_processor

Single-cycle 32-bit RISC core with a 12-bit instruction/data address space. Fetches from an external instruction memory, decodes, executes on an internal ALU, accesses an external data memory and drives an external 32×32 register file. It is the datapath/control top between imem, dmem and regfile in the system; the memories and the register file sit outside this block.

## Interface
- No parameters.
- `clock`: in, 1 bit. Master clock. All state updates on the rising edge.
- `reset`: in, 1 bit. Synchronous, active-high.
- `address_imem`: out, 12 bits. Fetch address; equals the PC.
- `q_imem`: in, 32 bits. Instruction at `address_imem`.
- `address_dmem`: out, 12 bits. Load/store word address.
- `data`: out, 32 bits. Store data to dmem.
- `wren`: out, 1 bit. dmem write enable.
- `q_dmem`: in, 32 bits. Load data from dmem.
- `ctrl_writeEnable`: out, 1 bit. Regfile write enable.
- `ctrl_writeReg`: out, 5 bits. Regfile destination.
- `ctrl_readRegA`: out, 5 bits. Regfile read port A select.
- `ctrl_readRegB`: out, 5 bits. Regfile read port B select.
- `data_writeReg`: out, 32 bits. Regfile write data.
- `data_readRegA`: in, 32 bits. Regfile port A data.
- `data_readRegB`: in, 32 bits. Regfile port B data.

## Operation
- Instruction fields:
  - opcode[31:27]
  - rd[26:22]
  - rs[21:17]
  - rt[16:12]
  - shamt[11:7]
  - aluop[6:2]
  - imm[16:0], sign-extended to 32 bits
  - target[26:0]
- R-type (opcode 00000), result rd = rs op rt, selected by aluop:
  - 00000 add
  - 00001 sub
  - 00010 and
  - 00011 or
  - 00100 sll (rs << shamt)
  - 00101 sra (rs >>> shamt)
  - Other aluop values: no write.
- addi 00101: rd = rs + imm.
- sw 00111: dmem[rs+imm] = $rd.
  - readRegB = rd.
  - `wren`=1.
  - `data` = `data_readRegB`.
- lw 01000: rd = dmem[rs+imm]. `data_writeReg` = `q_dmem`.
- j 00001: PC = target[11:0].
- bne 00010: if $rd != $rs then PC = PC+1+imm[11:0]. readRegA = rd, readRegB = rs.
- Read-port selects:
  - readRegA = rs and readRegB = rt, except for sw and bne as stated above.
- Address and write-enable outputs:
  - `address_dmem` = ALU sum [11:0] for both lw and sw.
  - `wren` is 0 for every instruction except sw.
- Unknown opcode: no register write, no memory write, PC+1.
- Writes with rd = 0 are suppressed (`ctrl_writeEnable`=0).
- Arithmetic is 32-bit two's complement; results wrap modulo 2^32.
- Overflow detection:
  - add/addi overflow when the operand signs are equal and the result sign differs.
  - sub overflow when the operand signs differ and the result sign differs from rs.

## Timing
- Single cycle per instruction. All outputs are combinational from the PC, `q_imem`, the regfile data and `q_dmem`.
- PC: 12-bit register.
  - Next PC = PC+1, wrapping 0xFFF→0x000, unless a jump or taken branch applies.
  - Updates on the `clock` rising edge.
- Regfile and dmem perform their writes on the same rising edge that advances the PC.
- Reset:
  - While `reset`=1 at a rising edge, PC←0.
  - While `reset` is high, `ctrl_writeEnable`=0 and `wren`=0 (forced, combinational).
  - `address_imem`=0 after the first reset edge.
- Reset asserted mid-program discards the current instruction's writes. Execution restarts at address 0 on the first edge after deassertion.

## Configuration
- `OVF_STATUS_EN` defined:
  - An overflowing add/addi/sub writes status to $r30 instead of rd: add→1, addi→2, sub→3.
  - `ctrl_writeReg`=30.
- `OVF_STATUS_EN` undefined: no overflow detection; the wrapped result is written to rd.

## Structure
- Package `mips_pkg` holds:
  - the opcode and aluop constants
  - the instruction field bit positions
  - the status codes 1/2/3
  - the status register index 30
- One sub-module, `mips_alu`:
  - ops: add, sub, and, or, sll, sra
  - outputs: result, overflow, not_equal
- Decode, PC and muxing stay in `mips_processor`.

## Test plan
- Reset held for 2 cycles → `address_imem`=0, `wren`=0, `ctrl_writeEnable`=0. First instruction is executed after deassertion.
- addi r1,r0,0xDEAD → `ctrl_writeReg`=1, `data_writeReg`=0x0000DEAD, `ctrl_writeEnable`=1. PC 0→1.
- add r3,r1,r2 with A=0x7FFFFFFF, B=1:
  - with `OVF_STATUS_EN` → write 1 to r30
  - without → write 0x80000000 to r3
- sw r1,4(r2) with $r2=8, $r1=0xDEAD → `address_dmem`=12, `data`=0xDEAD, `wren`=1, `ctrl_writeEnable`=0.
- lw r4,4(r2) with `q_dmem`=0x1234 → `ctrl_writeReg`=4, `data_writeReg`=0x1234, `wren`=0.
- bne taken at PC=5 with imm=-3 → next `address_imem`=3. j 0x0FF → next `address_imem`=0x0FF. addi r0,r0,5 → `ctrl_writeEnable`=0.
